// File: rtl/sdio_bus_mem_slave.sv
// Byte-wide DMA bus slave for the SDIO host: in-order command queue, on-chip byte memory,
// fixed read latency and optional LFSR-driven backpressure.
module sdio_bus_mem_slave #(
  parameter int unsigned AW      = 17,
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned RD_LAT  = 3,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic          bus_clk,
  input  logic          rst,
  input  logic          bus_rd,
  input  logic          bus_wr,
  input  logic [AW-1:0] bus_addr,
  input  logic [7:0]    bus_wdata,
  output logic          bus_ready,
  output logic          bus_rdata_ready,
  output logic [7:0]    bus_rdata,
  input  logic          cfg_stall_en,
  output logic          err_sticky,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt
);

  localparam int unsigned QW = $clog2(Q_DEPTH);
  localparam int unsigned EW = 1 + MEM_AW + 8;
  localparam logic [QW-1:0] PtrOne  = 1;
  localparam logic [QW:0]   QFull   = QW'(Q_DEPTH) == 0 ? (QW+1)'(Q_DEPTH) : (QW+1)'(Q_DEPTH);
  localparam logic [3:0]    LatInit = 4'(RD_LAT - 1);

  typedef enum logic [0:0] {StIdle, StRwait} state_e;

  state_e state_q, state_d;

  logic [EW-1:0]     q_mem [Q_DEPTH];
  logic [7:0]        mem [2**MEM_AW];
  logic [QW-1:0]     wptr_q, rptr_q;
  logic [QW:0]       cnt_q, cnt_d;
  logic [3:0]        wait_q;
  logic [MEM_AW-1:0] rd_addr_q;
  logic [7:0]        lfsr_q;
  logic              bus_ready_q, rdata_ready_q, err_q;
  logic [7:0]        rdata_q;
  logic [15:0]       rd_cnt_q, wr_cnt_q;

  logic              push, pop, full_next, bus_ready_d, lfsr_fb;
  logic              mem_we, rd_load, rd_fire;
  logic [EW-1:0]     head;
  logic              head_wr;
  logic [MEM_AW-1:0] head_addr;
  logic [7:0]        head_data;
  logic              unused_addr;

  assign unused_addr = ^bus_addr[AW-1:MEM_AW];

  assign push      = (bus_rd | bus_wr) & bus_ready_q;
  assign head      = q_mem[rptr_q];
  assign head_wr   = head[EW-1];
  assign head_addr = head[EW-2 -: MEM_AW];
  assign head_data = head[7:0];
  assign pop       = (state_q == StIdle) && (cnt_q != '0);

  assign cnt_d       = cnt_q + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};
  assign full_next   = (cnt_d == QFull);
  assign bus_ready_d = !full_next && !(cfg_stall_en && (lfsr_q[1:0] == 2'b00));
  // Taps x^8+x^6+x^5+x^4+1
  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop && !head_wr) state_d = StRwait;
      StRwait: if (wait_q == 4'd0)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we  = 1'b0;
    rd_load = 1'b0;
    rd_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_we  = pop & head_wr;
        rd_load = pop & ~head_wr;
      end
      StRwait: rd_fire = (wait_q == 4'd0);
      default: ;
    endcase
  end

  // Storage arrays carry no reset; the queue is emptied through its pointers.
  always_ff @(posedge bus_clk) begin
    if (push)   q_mem[wptr_q] <= {bus_wr, bus_addr[MEM_AW-1:0], bus_wdata};
    if (mem_we) mem[head_addr] <= head_data;
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      rd_addr_q     <= '0;
      lfsr_q        <= 8'hA5;
      bus_ready_q   <= 1'b0;
      rdata_ready_q <= 1'b0;
      rdata_q       <= 8'h00;
      err_q         <= 1'b0;
      rd_cnt_q      <= 16'h0000;
      wr_cnt_q      <= 16'h0000;
    end else begin
      lfsr_q        <= {lfsr_q[6:0], lfsr_fb};
      bus_ready_q   <= bus_ready_d;
      cnt_q         <= cnt_d;
      rdata_ready_q <= rd_fire;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      // Simultaneous rd+wr is accepted as a write; the read half is dropped.
      if (push && bus_rd && bus_wr) err_q <= 1'b1;
      if (mem_we) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rd_load) begin
        wait_q    <= LatInit;
        rd_addr_q <= head_addr;
      end else if (state_q == StRwait && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (rd_fire) begin
        rdata_q  <= mem[rd_addr_q];
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign bus_ready       = bus_ready_q;
  assign bus_rdata_ready = rdata_ready_q;
  assign bus_rdata       = rdata_q;
  assign err_sticky      = err_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_sdio_bus_mem_slave.sv
// Scoreboard bench for sdio_bus_mem_slave: driver pushes expected read data, monitor checks pulses.
module tb_sdio_bus_mem_slave;

  localparam int RD_LAT = 3;

  logic        bus_clk, rst, bus_rd, bus_wr, cfg_stall_en;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ready, bus_rdata_ready, err_sticky;
  logic [7:0]  bus_rdata;
  logic [15:0] rd_cnt, wr_cnt;

  sdio_bus_mem_slave #(.AW(17), .MEM_AW(12), .RD_LAT(RD_LAT), .Q_DEPTH(4)) dut (
    .bus_clk         (bus_clk),
    .rst             (rst),
    .bus_rd          (bus_rd),
    .bus_wr          (bus_wr),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_ready       (bus_ready),
    .bus_rdata_ready (bus_rdata_ready),
    .bus_rdata       (bus_rdata),
    .cfg_stall_en    (cfg_stall_en),
    .err_sticky      (err_sticky),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [4096];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         exp_rd = 0;
  int         exp_wr = 0;
  int         stall_waits = 0;

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;
  always @(posedge bus_clk) cyc <= cyc + 1;

  always @(negedge bus_clk) begin
    if (!rst && bus_rdata_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got pulse with data %02h, required no pulse", bus_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus_rdata !== e.data) begin
          errors++;
          $display("FAIL rdata: got %02h, required %02h", bus_rdata, e.data);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL rd_latency: pulse after edge %0d, required edge %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic rd, input logic wr, input logic [16:0] addr,
                       input logic [7:0] d, input bit chk_lat);
    int guard;
    exp_t e;
    bus_rd = rd; bus_wr = wr; bus_addr = addr; bus_wdata = d;
    guard = 0;
    while (!bus_ready && guard < 1000) begin
      @(negedge bus_clk);
      guard++;
      stall_waits++;
    end
    if (!bus_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout: got bus_ready=0 for 1000 cycles, required 1");
      bus_rd = 1'b0; bus_wr = 1'b0;
      return;
    end
    if (wr) begin
      mem_m[addr[11:0]] = d;
      exp_wr++;
    end else if (rd) begin
      e.data = mem_m[addr[11:0]];
      e.cyc  = chk_lat ? cyc + 2 + RD_LAT : -1;
      exp_q.push_back(e);
      exp_rd++;
    end
    @(negedge bus_clk);
  endtask

  task automatic idle();
    bus_rd = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge bus_clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d reads outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(negedge bus_clk);
  endtask

  initial begin
    rst = 1'b1; bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    cfg_stall_en = 1'b0;

    // 1: reset values and ready rise
    repeat (3) @(negedge bus_clk);
    chk("rst_bus_ready", 32'(bus_ready), 0);
    chk("rst_rdata_ready", 32'(bus_rdata_ready), 0);
    chk("rst_rdata", 32'(bus_rdata), 0);
    chk("rst_err", 32'(err_sticky), 0);
    chk("rst_rd_cnt", 32'(rd_cnt), 0);
    chk("rst_wr_cnt", 32'(wr_cnt), 0);
    rst = 1'b0;
    @(negedge bus_clk);
    chk("ready_after_rst", 32'(bus_ready), 1);

    // 2: write then read with latency check, plus address aliasing
    issue(1'b0, 1'b1, 17'h0_0010, 8'h5A, 1'b0);
    issue(1'b1, 1'b0, 17'h0_0010, 8'h00, 1'b1);
    idle();
    drain();
    chk("t2_wr_cnt", 32'(wr_cnt), 1);
    chk("t2_rd_cnt", 32'(rd_cnt), 1);
    issue(1'b0, 1'b1, 17'h1_0005, 8'hC3, 1'b0);
    issue(1'b1, 1'b0, 17'h0_0005, 8'h00, 1'b0);
    idle();
    drain();

    // 3: 512 back-to-back writes then reads, no backpressure
    stall_waits = 0;
    for (int i = 0; i < 512; i++) issue(1'b0, 1'b1, 17'(i), 8'(i), 1'b0);
    chk("t3_write_stalls", 32'(stall_waits), 0);
    for (int i = 0; i < 512; i++) issue(1'b1, 1'b0, 17'(i), 8'h00, 1'b0);
    idle();
    drain();
    chk("t3_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    chk("t3_rd_cnt", 32'(rd_cnt), 32'(exp_rd));

    // 4: same traffic with pseudo-random stalls
    cfg_stall_en = 1'b1;
    stall_waits = 0;
    for (int i = 0; i < 512; i++) issue(1'b0, 1'b1, 17'(i), ~8'(i), 1'b0);
    checks++;
    if (stall_waits == 0) begin
      errors++;
      $display("FAIL t4_stalls_seen: got %0d stall cycles, required >0", stall_waits);
    end
    for (int i = 0; i < 512; i++) issue(1'b1, 1'b0, 17'(i), 8'h00, 1'b0);
    idle();
    drain();
    cfg_stall_en = 1'b0;
    chk("t4_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    chk("t4_rd_cnt", 32'(rd_cnt), 32'(exp_rd));

    // 5: simultaneous rd+wr
    chk("t5_err_before", 32'(err_sticky), 0);
    issue(1'b1, 1'b1, 17'h0_0020, 8'h33, 1'b0);
    idle();
    drain();
    chk("t5_err_after", 32'(err_sticky), 1);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    chk("t5_rd_cnt", 32'(rd_cnt), 32'(exp_rd));

    // 6: reset while a read waits
    issue(1'b1, 1'b0, 17'h0_0010, 8'h00, 1'b0);
    idle();
    @(negedge bus_clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    repeat (3) @(negedge bus_clk);
    chk("t6_rd_cnt", 32'(rd_cnt), 0);
    chk("t6_wr_cnt", 32'(wr_cnt), 0);
    chk("t6_bus_ready", 32'(bus_ready), 0);
    chk("t6_err_cleared", 32'(err_sticky), 0);
    rst = 1'b0;
    repeat (6) @(negedge bus_clk);
    issue(1'b1, 1'b0, 17'h0_0020, 8'h00, 1'b0);
    issue(1'b1, 1'b0, 17'h0_0010, 8'h00, 1'b0);
    idle();
    drain();
    chk("t6_rd_cnt_after", 32'(rd_cnt), 32'(exp_rd));
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
